// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 16-deep show-ahead receive FIFO.
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   rst_n        in   synchronous active-low reset
//   uart_rx_pin  in   asynchronous serial line, idle high
//   read_uart    in   pop request for the FIFO head
//   uart_rx_data out  current FIFO head byte (valid while data_valid)
//   data_valid   out  FIFO holds at least one byte
//   frame_error  out  one-cycle pulse when a stop bit samples low
//   overrun      out  one-cycle pulse when a good byte is dropped on a full FIFO
//
// FSM states:
//   S_IDLE  | line idle, waiting for a falling edge
//   S_START | waiting half a bit to confirm the start bit
//   S_DATA  | sampling 8 data bits at mid-bit, LSB first
//   S_STOP  | sampling the stop bit, push or flag error
//   S_BREAK | stop bit was low; wait for the line to return high
module uart_rx #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx_pin,
    input  logic       read_uart,
    output logic [7:0] uart_rx_data,
    output logic       data_valid,
    output logic       frame_error,
    output logic       overrun
);

    localparam int BAUD_DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_DIVISOR = BAUD_DIVISOR / 2;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIVISOR - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_DIVISOR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic        rx_meta_q, rx_s_q;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        push_req;
    logic        frame_error_q, frame_error_d;
    logic        overrun_q, overrun_d;

    logic [7:0]  fifo_q [16];
    logic [3:0]  head_q, head_d;
    logic [3:0]  tail_q, tail_d;
    logic [4:0]  count_q, count_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        data_valid_q, data_valid_d;
    logic        pop, full, push_ok;

    // Receive FSM: next state and datapath.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        push_req      = 1'b0;
        frame_error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // A line back high at mid-start-bit is a glitch, not a frame.
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == BAUD_LAST) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push_req = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO control. A pop in the same cycle frees the slot a full-FIFO push needs.
    always_comb begin
        pop       = read_uart && (count_q != 5'd0);
        full      = (count_q == 5'd16);
        push_ok   = push_req && (!full || pop);
        overrun_d = push_req && full && !pop;
        head_d    = pop ? head_q + 4'd1 : head_q;
        tail_d    = push_ok ? tail_q + 4'd1 : tail_q;
        count_d   = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 5'd1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 5'd1;
        end
        data_valid_d = (count_d != 5'd0);
        // Show-ahead: if the slot being written becomes the head, bypass the array.
        rx_data_d = rx_data_q;
        if (count_d != 5'd0) begin
            if (push_ok && (tail_q == head_d)) begin
                rx_data_d = shift_q;
            end else begin
                rx_data_d = fifo_q[head_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            rx_data_q     <= 8'h00;
            data_valid_q  <= 1'b0;
        end else begin
            rx_meta_q     <= uart_rx_pin;
            rx_s_q        <= rx_meta_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            rx_data_q     <= rx_data_d;
            data_valid_q  <= data_valid_d;
        end
    end

    // Storage is not reset; the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            fifo_q[tail_q] <= shift_q;
        end
    end

    assign uart_rx_data = rx_data_q;
    assign data_valid   = data_valid_q;
    assign frame_error  = frame_error_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: behavioural FIFO/frame model plus directed and random frames.
module tb_uart_rx;

    localparam int CLK_HZ   = 1_700_000;
    localparam int BAUD     = 100_000;
    localparam int B        = CLK_HZ / BAUD;   // clocks per bit
    localparam int H        = B / 2;           // half bit
    // Edges from the edge after which the start bit is driven to the stop-sample edge:
    // 2 synchronizer edges + 1 edge for IDLE to see it, then H + 9*B.
    localparam int PUSH_LAT = 3 + H + 9 * B;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pin = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] uart_rx_data;
    logic       data_valid, frame_error, overrun;

    uart_rx #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_rx_pin  (pin),
        .read_uart    (rd),
        .uart_rx_data (uart_rx_data),
        .data_valid   (data_valid),
        .frame_error  (frame_error),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int last_push_edge = 0;
    bit checking = 1'b0;

    typedef struct {
        int           edge_n;
        bit           good;
        byte unsigned data;
    } ev_t;

    byte unsigned mq[$];
    ev_t          evq[$];
    bit           exp_fe, exp_ov;
    bit           m_pop;
    int           m_size;
    ev_t          m_ev;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: a frame's outcome lands on a fixed edge; pops and pushes resolve on that edge.
    always @(posedge clk) begin
        cyc++;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        if (!rst_n) begin
            mq.delete();
            evq.delete();
        end else begin
            m_size = mq.size();
            m_pop  = rd && (m_size > 0);
            if (m_pop) void'(mq.pop_front());
            while (evq.size() > 0 && evq[0].edge_n < cyc) void'(evq.pop_front());
            if (evq.size() > 0 && evq[0].edge_n == cyc) begin
                m_ev = evq.pop_front();
                if (!m_ev.good) exp_fe = 1'b1;
                else if (m_size < 16 || m_pop) mq.push_back(m_ev.data);
                else exp_ov = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (frame_error) fe_cnt++;
        if (overrun) ov_cnt++;
        if (checking) begin
            chk("data_valid", {7'd0, data_valid}, {7'd0, mq.size() != 0});
            if (mq.size() != 0) chk("rx_data", uart_rx_data, mq[0]);
            chk("frame_error", {7'd0, frame_error}, {7'd0, exp_fe});
            chk("overrun", {7'd0, overrun}, {7'd0, exp_ov});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input byte unsigned b, input bit stop_ok, input int extra_low_bits);
        ev_t e;
        @(posedge clk);
        #1;
        e.edge_n = cyc + PUSH_LAT;
        e.good   = stop_ok;
        e.data   = b;
        last_push_edge = e.edge_n;
        evq.push_back(e);
        pin = 1'b0;
        tick(B);
        for (int i = 0; i < 8; i++) begin
            pin = b[i];
            tick(B);
        end
        pin = stop_ok;
        tick(B);
        if (!stop_ok) begin
            tick(extra_low_bits * B);
            pin = 1'b1;
            tick(2);
        end
    endtask

    task automatic glitch(input int len);
        @(posedge clk);
        #1;
        pin = 1'b0;
        tick(len);
        pin = 1'b1;
        tick(B + H);
    endtask

    task automatic pop1();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0, ov0, mode;
        byte unsigned rb;
        rst_n = 1'b0;
        tick(3);
        chk("reset data_valid", {7'd0, data_valid}, 8'd0);
        chk("reset rx_data", uart_rx_data, 8'h00);
        chk("reset frame_error", {7'd0, frame_error}, 8'd0);
        chk("reset overrun", {7'd0, overrun}, 8'd0);
        checking = 1'b1;
        rst_n = 1'b1;
        tick(4);

        // Two bytes, show-ahead, pops.
        send_frame(8'h55, 1'b1, 0);
        send_frame(8'hA3, 1'b1, 0);
        chk("two bytes valid", {7'd0, data_valid}, 8'd1);
        chk("first byte", uart_rx_data, 8'h55);
        pop1();
        chk("second byte", uart_rx_data, 8'hA3);
        pop1();
        chk("empty after pops", {7'd0, data_valid}, 8'd0);

        // Bad stop bit followed by a held-low line, then a good frame.
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 20);
        chk("break one frame_error", 8'(fe_cnt - fe0), 8'd1);
        chk("break no push", {7'd0, data_valid}, 8'd0);
        tick(B);
        send_frame(8'h81, 1'b1, 0);
        chk("after break byte", uart_rx_data, 8'h81);
        pop1();

        // Short glitch on an idle line.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        glitch(H - 2);
        chk("glitch no push", {7'd0, data_valid}, 8'd0);
        chk("glitch no error", 8'(fe_cnt - fe0 + ov_cnt - ov0), 8'd0);

        // Overfill: 17 bytes, one overrun, 0x00..0x0F out in order.
        ov0 = ov_cnt;
        for (int i = 0; i <= 16; i++) send_frame(byte'(i), 1'b1, 0);
        chk("overrun once", 8'(ov_cnt - ov0), 8'd1);
        for (int i = 0; i < 16; i++) begin
            chk("overfill order", uart_rx_data, 8'(i));
            pop1();
        end
        chk("overfill drained", {7'd0, data_valid}, 8'd0);

        // Full FIFO with a pop in the exact stop-sample cycle.
        for (int i = 0; i < 16; i++) send_frame(8'h30 + 8'(i), 1'b1, 0);
        ov0 = ov_cnt;
        fork
            send_frame(8'hEE, 1'b1, 0);
            begin
                tick(2);
                while (cyc < last_push_edge - 1) tick(1);
                pop1();
            end
        join
        chk("full pop no overrun", 8'(ov_cnt - ov0), 8'd0);
        for (int i = 1; i < 16; i++) begin
            chk("full pop order", uart_rx_data, 8'h30 + 8'(i));
            pop1();
        end
        chk("last is EE", uart_rx_data, 8'hEE);
        pop1();
        chk("full pop drained", {7'd0, data_valid}, 8'd0);

        // Reset in the middle of bit 4 with one byte already buffered.
        send_frame(8'h5A, 1'b1, 0);
        chk("pre-reset valid", {7'd0, data_valid}, 8'd1);
        @(posedge clk);
        #1;
        pin = 1'b0;
        tick(B);
        rb = 8'h6F;
        for (int i = 0; i < 4; i++) begin
            pin = rb[i];
            tick(B);
        end
        pin = rb[4];
        tick(H);
        rst_n = 1'b0;
        pin = 1'b1;
        tick(1);
        chk("in reset valid", {7'd0, data_valid}, 8'd0);
        chk("in reset data", uart_rx_data, 8'h00);
        chk("in reset fe", {7'd0, frame_error}, 8'd0);
        chk("in reset ov", {7'd0, overrun}, 8'd0);
        tick(2);
        rst_n = 1'b1;
        tick(12 * B);
        chk("aborted not stored", {7'd0, data_valid}, 8'd0);
        send_frame(8'h7E, 1'b1, 0);
        chk("post-reset byte", uart_rx_data, 8'h7E);
        pop1();

        // Random frames, glitches, bad stops and concurrent pops.
        for (int it = 0; it < 50; it++) begin
            mode = $urandom_range(0, 2);
            fork
                begin
                    case ($urandom_range(0, 9))
                        0: glitch($urandom_range(1, H));
                        1: send_frame(byte'($urandom_range(0, 255)), 1'b0, $urandom_range(0, 2));
                        default: send_frame(byte'($urandom_range(0, 255)), 1'b1, 0);
                    endcase
                end
                begin
                    for (int k = 0; k < 10 * B; k++) begin
                        rd = (mode == 2) ? ($urandom_range(0, 7) == 0) :
                             (mode == 1) ? ($urandom_range(0, 63) == 0) : 1'b0;
                        tick(1);
                    end
                    rd = 1'b0;
                end
            join
            tick($urandom_range(2, B));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
